// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction bus, execute redirect and the decode-side output register.
// master = fetch stage, slave = the bus/execute/decode environment around it.
interface fetch_stage_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        d_ready;
    logic        d_valid;
    logic [63:0] d_pc;
    logic [31:0] d_instr;

    modport master (
        output ireq_valid, ireq_addr, d_valid, d_pc, d_instr,
        input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, d_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, d_valid, d_pc, d_instr,
        output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, d_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with single-entry IF/ID register; one bus request outstanding at a time.
// Latency: response in cycle t -> d_valid in t+1; zero-wait bus sustains one instruction per cycle.
// Backpressure: a request is only issued when the output slot will drain; stalled decode holds the output.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic {FETCH, DROP} state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] instr;
    } dec_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_addr;
    logic        req_active;
    logic        d_valid_q;
    dec_t        d_q;

    logic        slot_free;
    logic        issue;
    logic        resp;

    assign slot_free = !d_valid_q || bus.d_ready;

    // A new request goes out only when nothing is pending and the response can land in a free slot.
    assign issue = !reset && (state == FETCH) && !req_active && !bus.redirect_valid && slot_free;
    assign resp  = bus.iresp_data_ok && (req_active || issue);

    assign bus.ireq_valid = !reset && (req_active || issue);
    assign bus.ireq_addr  = req_active ? req_addr : pc;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_pc       = d_q.addr;
    assign bus.d_instr    = d_q.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            req_active <= 1'b0;
            state      <= FETCH;
            d_valid_q  <= 1'b0;
            d_q        <= '0;
        end else if (bus.redirect_valid) begin
            pc        <= bus.redirect_pc;
            d_valid_q <= 1'b0;
            // The in-flight fetch is stale: consume it now if it returns, otherwise wait it out in DROP.
            if (req_active && bus.iresp_data_ok) begin
                req_active <= 1'b0;
                state      <= FETCH;
            end else if (req_active) begin
                state <= DROP;
            end
        end else begin
            if (d_valid_q && bus.d_ready) begin
                d_valid_q <= 1'b0;
            end
            if (state == DROP) begin
                if (bus.iresp_data_ok) begin
                    req_active <= 1'b0;
                    state      <= FETCH;
                end
            end else if (resp) begin
                d_valid_q  <= 1'b1;
                d_q        <= '{addr: pc, instr: bus.iresp_data};
                pc         <= pc + 64'd4;
                req_active <= 1'b0;
            end else if (issue) begin
                req_active <= 1'b1;
                req_addr   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed redirect/reset sequences, randomized bus with scoreboard.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rdy;
        logic        ok;
        logic [31:0] data;
        logic        exp_iv;
        logic [63:0] exp_ia;
        logic        exp_dv;
        logic        chk_d;
        logic [63:0] exp_dpc;
        logic [31:0] exp_di;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic ok, input logic [31:0] data,
                       input logic redir, input logic [63:0] rpc);
        @(negedge clk);
        reset              = rst;
        bus.d_ready        = rdy;
        bus.iresp_data_ok  = ok;
        bus.iresp_data     = data;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    function automatic vec_t mk(logic rdy, logic ok, logic [31:0] data, logic iv, logic [63:0] ia,
                                logic dv, logic cd, logic [63:0] dpc, logic [31:0] di);
        vec_t v;
        v.rdy = rdy; v.ok = ok; v.data = data; v.exp_iv = iv; v.exp_ia = ia;
        v.exp_dv = dv; v.chk_d = cd; v.exp_dpc = dpc; v.exp_di = di;
        return v;
    endfunction

    function automatic logic [31:0] s_word(int k);
        return (k == 0) ? 32'h0000_0013 : (32'hA000_0000 | 32'(k));
    endfunction

    function automatic logic [31:0] mem(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    initial begin
        logic        busy, rdy, redir, ok;
        logic [63:0] raddr, rpc, exp_pc, prev_dpc;
        logic [31:0] prev_di;
        logic        prev_stall, prev_redir;
        int          rwait, delivered;

        // Streaming, then wait states and a decode stall; rows are cycles after reset release.
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1, 1, s_word(k), 1, RST_PC + 64'(4 * k), k > 0, 1,
                        (k > 0) ? RST_PC + 64'(4 * (k - 1)) : 64'd0, (k > 0) ? s_word(k - 1) : 32'd0);
        tbl[8]  = mk(1, 0, 0, 1, RST_PC + 64'h20, 1, 1, RST_PC + 64'h1C, s_word(7));
        tbl[9]  = mk(1, 0, 0, 1, RST_PC + 64'h20, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 1, RST_PC + 64'h20, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, s_word(8), 1, RST_PC + 64'h20, 0, 0, 0, 0);
        for (int k = 12; k < 17; k++)
            tbl[k] = mk(0, 0, 0, 0, 0, 1, 1, RST_PC + 64'h20, s_word(8));
        tbl[17] = mk(1, 1, s_word(9), 1, RST_PC + 64'h24, 1, 1, RST_PC + 64'h20, s_word(8));
        tbl[18] = mk(1, 0, 0, 1, RST_PC + 64'h28, 1, 1, RST_PC + 64'h24, s_word(9));

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_iv", bus.ireq_valid, 0);
        chk("reset_ia", bus.ireq_addr, RST_PC);
        chk("reset_dv", bus.d_valid, 0);

        for (int i = 0; i < 19; i++) begin
            cyc(0, tbl[i].rdy, tbl[i].ok, tbl[i].data, 0, 0);
            chk($sformatf("vec%0d_iv", i), bus.ireq_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv) chk($sformatf("vec%0d_ia", i), bus.ireq_addr, tbl[i].exp_ia);
            chk($sformatf("vec%0d_dv", i), bus.d_valid, tbl[i].exp_dv);
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d_dpc", i), bus.d_pc, tbl[i].exp_dpc);
                chk($sformatf("vec%0d_di", i), bus.d_instr, tbl[i].exp_di);
            end
        end

        // Redirect while a request is outstanding: stale response must be dropped.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h13, 0, 0);
        chk("seq_first_ia", bus.ireq_addr, RST_PC);
        cyc(0, 1, 1, 32'h17, 0, 0);
        chk("seq_first_dpc", bus.d_pc, RST_PC);
        cyc(0, 1, 0, 0, 0, 0);
        chk("seq_wait_ia", bus.ireq_addr, RST_PC + 64'h8);
        cyc(0, 1, 0, 0, 1, RST_PC + 64'h100);
        chk("redir_hold_iv", bus.ireq_valid, 1);
        chk("redir_hold_ia", bus.ireq_addr, RST_PC + 64'h8);
        cyc(0, 1, 0, 0, 0, 0);
        chk("drop_ia", bus.ireq_addr, RST_PC + 64'h8);
        cyc(0, 1, 1, 32'hDEAD_BEEF, 0, 0);
        chk("drop_resp_ia", bus.ireq_addr, RST_PC + 64'h8);
        cyc(0, 1, 1, 32'h0000_1111, 0, 0);
        chk("stale_dropped_dv", bus.d_valid, 0);
        chk("redir_target_ia", bus.ireq_addr, RST_PC + 64'h100);
        cyc(0, 1, 0, 0, 0, 0);
        chk("redir_target_dpc", bus.d_pc, RST_PC + 64'h100);
        chk("redir_target_di", bus.d_instr, 32'h0000_1111);

        // Redirect coincident with data_ok: discard, no DROP cycle.
        cyc(0, 1, 1, 32'hBAD0_0BAD, 1, RST_PC + 64'h200);
        chk("coinc_ia", bus.ireq_addr, RST_PC + 64'h104);
        cyc(0, 1, 1, 32'h0000_2222, 0, 0);
        chk("coinc_dv", bus.d_valid, 0);
        chk("coinc_next_ia", bus.ireq_addr, RST_PC + 64'h200);
        chk("coinc_next_iv", bus.ireq_valid, 1);
        // Redirect with a held instruction: flushed, and no issue in the redirect cycle.
        cyc(0, 0, 0, 0, 1, RST_PC + 64'h300);
        chk("flush_pre_dpc", bus.d_pc, RST_PC + 64'h200);
        chk("redir_no_issue", bus.ireq_valid, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("flush_dv", bus.d_valid, 0);
        chk("flush_ia", bus.ireq_addr, RST_PC + 64'h300);

        // Reset while in DROP, late data_ok during reset, then wrap-around fetch.
        cyc(0, 1, 0, 0, 1, RST_PC + 64'h400);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h0000_FACE, 0, 0);
        chk("rst_drop_iv", bus.ireq_valid, 0);
        chk("rst_drop_ia", bus.ireq_addr, RST_PC);
        cyc(0, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst_drop_dv", bus.d_valid, 0);
        chk("rst_drop_dpc", bus.d_pc, 0);
        chk("rst_drop_di", bus.d_instr, 0);
        cyc(0, 1, 1, 32'h0000_3333, 0, 0);
        chk("wrap_top_ia", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 0);
        chk("wrap_dpc", bus.d_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_ia", bus.ireq_addr, 64'h0);

        // Randomized traffic: in-order PC stream from the last redirect target, bus as a memory.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        busy = 0; raddr = 0; rwait = 0; exp_pc = RST_PC; delivered = 0;
        prev_stall = 0; prev_redir = 0; prev_dpc = 0; prev_di = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            cyc(0, rdy, 0, 0, redir, rpc);

            if (prev_redir) chk("rnd_flush_dv", bus.d_valid, 0);
            if (prev_stall) begin
                chk("rnd_hold_dv", bus.d_valid, 1);
                chk("rnd_hold_dpc", bus.d_pc, prev_dpc);
                chk("rnd_hold_di", bus.d_instr, prev_di);
            end
            if (!busy) begin
                chk("rnd_issue", bus.ireq_valid, !redir && (!bus.d_valid || rdy));
            end else begin
                chk("rnd_req_held", bus.ireq_valid, 1);
                chk("rnd_addr_stable", bus.ireq_addr, raddr);
            end
            if (bus.d_valid && rdy) begin
                chk("rnd_dpc", bus.d_pc, exp_pc);
                chk("rnd_di", bus.d_instr, mem(exp_pc));
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (redir) exp_pc = rpc;

            if (bus.ireq_valid && !busy) begin
                busy  = 1;
                raddr = bus.ireq_addr;
                rwait = $urandom_range(0, 3);
            end
            ok = 0;
            if (busy) begin
                if (rwait == 0) begin
                    ok   = 1;
                    busy = 0;
                end else begin
                    rwait--;
                end
            end
            bus.iresp_data_ok = ok;
            bus.iresp_data    = mem(raddr);

            prev_stall = bus.d_valid && !rdy && !redir;
            prev_dpc   = bus.d_pc;
            prev_di    = bus.d_instr;
            prev_redir = redir;
        end
        chk("rnd_progress", 64'(delivered > 200), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
